// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned NIB  = 4;
  localparam int unsigned MAXW = 128;

  typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_state_t;

  function automatic int unsigned ncyc(input int unsigned binlen, input int unsigned step);
    return (binlen + step - 1) / step;
  endfunction

  // Wide enough for both the operand and 10**declen (log2(10) < 3.33).
  function automatic int unsigned cmp_width(input int unsigned binlen, input int unsigned declen);
    int unsigned dw;
    dw = (declen * 333 + 99) / 100 + 1;
    return (binlen > dw) ? binlen : dw;
  endfunction

  function automatic logic pow10_ge(input logic [MAXW-1:0] value, input int unsigned declen);
    logic [MAXW-1:0] p;
    p = MAXW'(1);
    for (int unsigned i = 0; i < declen; i++) p = p * MAXW'(10);
    return value >= p;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble layer: add 3 to every nibble above 4, then shift one operand bit in.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int unsigned DECLEN = 9
)(
  input  logic [DECLEN*NIB-1:0] acc,
  input  logic                  sbit,
  output logic [DECLEN*NIB-1:0] acc_nxt
);

  localparam int unsigned W = DECLEN * NIB;

  logic [W-1:0] adj;

  always_comb begin
    adj = acc;
    for (int unsigned d = 0; d < DECLEN; d++) begin
      if (acc[d*NIB +: NIB] > 4'd4) adj[d*NIB +: NIB] = acc[d*NIB +: NIB] + 4'd3;
    end
  end

  // The top bit falls off: the result wraps modulo 10**DECLEN.
  assign acc_nxt = W'({adj, sbit});

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, STEP bits per clock, valid/ready on both sides.
// Define BCD_SIGN_EN for two's-complement input with a neg output.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BINLEN = 30,
  parameter int unsigned DECLEN = 9,
  parameter int unsigned STEP   = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BINLEN-1:0]     BIN,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DECLEN*NIB-1:0] BCD,
  output logic                  ovf
`ifdef BCD_SIGN_EN
  ,
  output logic                  neg
`endif
);

  localparam int unsigned NCYC = ncyc(BINLEN, STEP);
  localparam int unsigned SRW  = NCYC * STEP;
  localparam int unsigned ACCW = DECLEN * NIB;
  localparam int unsigned CMPW = cmp_width(BINLEN, DECLEN);
  localparam int unsigned CNTW = (NCYC > 1) ? $clog2(NCYC) : 1;

  bcd_state_t       state;
  logic [SRW-1:0]   sr;
  logic [ACCW-1:0]  acc;
  logic [CNTW-1:0]  cnt;
  logic [BINLEN-1:0] mag;
  logic [CMPW-1:0]  mag_cmp;
  logic [ACCW-1:0]  acc_step;

`ifdef BCD_SIGN_EN
  logic sign;
  // Negating the most negative value wraps to 2**(BINLEN-1), which is the correct magnitude.
  assign sign = BIN[BINLEN-1];
  assign mag  = sign ? ((~BIN) + BINLEN'(1)) : BIN;
`else
  assign mag  = BIN;
`endif

  assign mag_cmp = CMPW'(mag);

  for (genvar j = 0; j < STEP; j++) begin : g_layer
    logic [ACCW-1:0] acc_in;
    logic [ACCW-1:0] acc_nxt;
    if (j == 0) begin : g_first
      assign acc_in = acc;
    end else begin : g_next
      assign acc_in = g_layer[j-1].acc_nxt;
    end
    bcd_dabble_step #(.DECLEN(DECLEN)) u_step (
      .acc     (acc_in),
      .sbit    (sr[SRW-1-j]),
      .acc_nxt (acc_nxt)
    );
  end

  assign acc_step = g_layer[STEP-1].acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      BCD       <= '0;
      ovf       <= 1'b0;
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef BCD_SIGN_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sr       <= SRW'(mag);
            acc      <= '0;
            ovf      <= pow10_ge(MAXW'(mag_cmp), DECLEN);
            cnt      <= CNTW'(NCYC - 1);
            in_ready <= 1'b0;
            state    <= CONV;
`ifdef BCD_SIGN_EN
            neg      <= sign;
`endif
          end
        end
        CONV: begin
          acc <= acc_step;
          sr  <= sr << STEP;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            BCD       <= acc_step;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq at STEP=1, 4 and 30 (BINLEN=30, DECLEN=9).
// Build with BCD_SIGN_EN defined to exercise the signed vectors.
module tb_bin2bcd_seq;

  typedef struct {
    logic [35:0] bcd;
    logic        ovf;
    logic        neg;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [29:0] BIN = '0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        in_valid_v[3];
  logic        in_ready_v[3];
  logic        out_valid_v[3];
  logic        ovf_v[3];
  logic [35:0] bcd_v[3];
`ifdef BCD_SIGN_EN
  logic        neg_v[3];
`endif

  exp_t sb[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S  = (g == 0) ? 1 : (g == 1) ? 4 : 30;
    localparam int          NC = (g == 0) ? 30 : (g == 1) ? 8 : 1;
    logic prev_v = 1'b0;
    exp_t e;

    assign in_valid_v[g] = in_valid && (sel == g);

    bin2bcd_seq #(.BINLEN(30), .DECLEN(9), .STEP(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .BIN       (BIN),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .BCD       (bcd_v[g]),
      .ovf       (ovf_v[g])
`ifdef BCD_SIGN_EN
      ,
      .neg       (neg_v[g])
`endif
    );

    // Valid rises NC edges after the accepting edge (visible in cycle k+NCYC+1).
    always @(negedge clk) begin
      if (rst_n && out_valid_v[g]) begin
        if (sb[g].size() == 0) begin
          chk($sformatf("unexpected_out[%0d]", g), 64'(out_valid_v[g]), 64'(0));
        end else begin
          e = sb[g][0];
          if (!prev_v) chk($sformatf("latency[%0d]", g), 64'(cyc - e.acc), 64'(NC));
          chk($sformatf("in_ready_busy[%0d]", g), 64'(in_ready_v[g]), 64'(0));
          chk($sformatf("bcd[%0d]", g), 64'(bcd_v[g]), 64'(e.bcd));
          chk($sformatf("ovf[%0d]", g), 64'(ovf_v[g]), 64'(e.ovf));
`ifdef BCD_SIGN_EN
          chk($sformatf("neg[%0d]", g), 64'(neg_v[g]), 64'(e.neg));
`endif
          if (out_ready) void'(sb[g].pop_front());
        end
      end
      prev_v = rst_n && out_valid_v[g];
    end
  end

  task automatic send(input int idx, input logic [29:0] b, input logic [35:0] eb,
                      input logic eo, input logic en);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!in_ready_v[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready_v[idx]), 64'(1));
    if (!in_ready_v[idx]) return;
    sel = idx;
    BIN = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    x.bcd = eb;
    x.ovf = eo;
    x.neg = en;
    x.acc = cyc;
    sb[idx].push_back(x);
    in_valid = 1'b0;
    BIN = 30'($urandom);
  endtask

  task automatic wait_idle(input int idx);
    int n;
    n = 0;
    while (sb[idx].size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("drain[%0d]", idx), 64'(sb[idx].size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 64'(in_ready_v[i]), 64'(1));
      chk("rst_out_valid", 64'(out_valid_v[i]), 64'(0));
      chk("rst_bcd", 64'(bcd_v[i]), 64'(0));
      chk("rst_ovf", 64'(ovf_v[i]), 64'(0));
    end
    rst_n = 1'b1;

`ifdef BCD_SIGN_EN
    send(0, 30'd123456789, 36'h123456789, 1'b0, 1'b0);
    send(0, 30'h3FFFFFFF,  36'h000000001, 1'b0, 1'b1);
    send(0, 30'h20000000,  36'h536870912, 1'b0, 1'b1);
    send(0, 30'h3FFFFFD6,  36'h000000042, 1'b0, 1'b1);
`else
    send(0, 30'd123456789,  36'h123456789, 1'b0, 1'b0);
    send(0, 30'd999999999,  36'h999999999, 1'b0, 1'b0);
    send(0, 30'd1000000000, 36'h000000000, 1'b1, 1'b0);
    send(0, 30'd0,          36'h000000000, 1'b0, 1'b0);
`endif
    wait_idle(0);

    // Downstream stall: result and out_valid held, in_ready low.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 30'd456789012, 36'h456789012, 1'b0, 1'b0);
    n = 0;
    while (!out_valid_v[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_valid_rise", 64'(out_valid_v[0]), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("stall_valid_held", 64'(out_valid_v[0]), 64'(1));
    chk("stall_in_ready", 64'(in_ready_v[0]), 64'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 64'(out_valid_v[0]), 64'(0));
    chk("release_in_ready", 64'(in_ready_v[0]), 64'(1));
    wait_idle(0);

    // Reset in the tenth conversion cycle discards the in-flight result.
    send(0, 30'd55555555, 36'h055555555, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb[0].delete();
    chk("midrst_in_ready", 64'(in_ready_v[0]), 64'(1));
    chk("midrst_out_valid", 64'(out_valid_v[0]), 64'(0));
    chk("midrst_bcd", 64'(bcd_v[0]), 64'(0));
    rst_n = 1'b1;
    send(0, 30'd42, 36'h000000042, 1'b0, 1'b0);
    wait_idle(0);

`ifdef BCD_SIGN_EN
    send(1, 30'h3FFFFFFF, 36'h000000001, 1'b0, 1'b1);
    send(1, 30'h1FFFFFFF, 36'h536870911, 1'b0, 1'b0);
    send(2, 30'h20000000, 36'h536870912, 1'b0, 1'b1);
    send(2, 30'd7,        36'h000000007, 1'b0, 1'b0);
`else
    send(1, 30'h3FFFFFFF,   36'h073741823, 1'b1, 1'b0);
    send(1, 30'd123456789,  36'h123456789, 1'b0, 1'b0);
    send(2, 30'h3FFFFFFF,   36'h073741823, 1'b1, 1'b0);
    send(2, 30'd999999999,  36'h999999999, 1'b0, 1'b0);
    send(2, 30'd1000000000, 36'h000000000, 1'b1, 1'b0);
`endif
    wait_idle(1);
    wait_idle(2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
